// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter: a byte FIFO feeding a start/data/parity/stop serializer.
// Queued bytes leave as back-to-back frames; the line idles high.
module uart_tx #(
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         pi_data,
  input  logic               pi_flag,
  output logic               pi_ready,
  output logic               ovf_pulse,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               tx_busy,
  output logic               tx
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int unsigned DEPTH        = 1 << FIFO_AW;
  localparam int unsigned CNT_W        = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_ovf;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;

  logic               w_full;
  logic               w_empty;
  logic               w_wr;
  logic               w_pop;
  logic               w_baud_end;
  logic               w_last_stop;
  logic               w_parity;
  logic [7:0]         w_head;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_wr        = pi_flag & ~w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_end  = (r_baud_cnt == BAUD_W'(BAUD_CNT_MAX - 1));
  assign w_last_stop = (r_bit_cnt == 3'(STOP_BITS - 1));
  assign w_parity    = (^r_shift) ^ 1'(PARITY_ODD);

  // The FSM is the only consumer: pop when idle, or when the last stop bit ends.
  assign w_pop = ~w_empty &
                 ((r_state == S_IDLE) |
                  ((r_state == S_STOP) & w_baud_end & w_last_stop));

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_W'(DEPTH));
      r_ovf   <= pi_flag & w_full;
    end
  end

  // Serializer: baud counter restarts on every bit boundary and stays at 0 while idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_baud_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= w_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[r_bit_cnt + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (w_baud_end) begin
            r_state   <= S_STOP;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            if (w_last_stop) begin
              r_bit_cnt <= '0;
              if (!w_empty) begin
                r_shift <= w_head;
                r_tx    <= 1'b0;
                r_state <= S_START;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pi_ready  = r_ready;
  assign ovf_pulse = r_ovf;
  assign fifo_cnt  = r_cnt;
  assign tx_busy   = r_busy;
  assign tx        = r_tx;

endmodule
